// File: rtl/fmeasure_pkg.sv
// Shared types and defaults for the frequency-meter host controller.
package fmeasure_pkg;

    localparam int unsigned DEFAULT_REF_HZ  = 50_000_000;
    localparam int unsigned DEFAULT_TIMEOUT = 67_108_864;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_BUSY,
        WAIT_DONE,
        CALC,
        DIV,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_TIMEOUT  = 2'd1,
        ERR_DIV0     = 2'd2,
        ERR_OVERFLOW = 2'd3
    } err_t;

endpackage

// File: rtl/fm_divider.sv
// 64/32 restoring divider, one quotient bit per cycle, 32 cycles after load.
// done is high during the final step; quotient carries that step's result.
module fm_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [63:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient
);

    logic [31:0] rem, low, quo, divs;
    logic [4:0]  count;
    logic        running;
    logic [32:0] partial, trial;
    logic        qbit;
    logic [31:0] rem_next;

    // Caller guarantees dividend[63:32] < divisor, so the remainder fits 32 bits.
    assign partial  = {rem, low[31]};
    assign trial    = partial - {1'b0, divs};
    assign qbit     = ~trial[32];
    assign rem_next = qbit ? trial[31:0] : partial[31:0];
    assign quotient = {quo[30:0], qbit};
    assign done     = running && (count == 5'd31);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem     <= '0;
            low     <= '0;
            quo     <= '0;
            divs    <= '0;
            count   <= '0;
            running <= 1'b0;
        end else if (load) begin
            rem     <= dividend[63:32];
            low     <= dividend[31:0];
            divs    <= divisor;
            quo     <= '0;
            count   <= '0;
            running <= 1'b1;
        end else if (running) begin
            rem   <= rem_next;
            low   <= {low[30:0], 1'b0};
            quo   <= quotient;
            count <= count + 5'd1;
            if (count == 5'd31)
                running <= 1'b0;
        end
    end

endmodule

// File: rtl/fm_host.sv
// Host controller: triggers the meter, waits with timeout, and converts the
// captured cycle counts into a frequency via a serial divider.
module fm_host
    import fmeasure_pkg::*;
#(
    parameter int unsigned REF_HZ  = DEFAULT_REF_HZ,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    output logic        trig,
    input  logic        meter_busy,
    input  logic [31:0] ca,
    input  logic [31:0] cb,
    output logic [31:0] freq,
    output logic        valid,
    output logic [1:0]  err,
    output logic        busy
);

    localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

    state_t      state, state_next;
    logic [31:0] ca_r, cb_r, cnt, cnt_next;
    logic [63:0] product;
    logic        timed_out, capture, div0, overflow;
    logic        div_load, div_done;
    logic [31:0] quotient;
    logic [31:0] freq_r, res_freq;
    err_t        err_r, res_err;

    assign cnt_next  = cnt + 32'd1;
    assign timed_out = (cnt_next == TIMEOUT_W);
    assign capture   = (state == WAIT_DONE) && !meter_busy;
    assign product   = 64'(ca_r) * 64'(REF_HZ);
    assign div0      = (cb_r == '0);
    assign overflow  = (product[63:32] >= cb_r);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        res_freq   = '0;
        res_err    = ERR_OK;
        case (state)
            IDLE:      if (req) state_next = TRIG;
            TRIG:      state_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (timed_out) begin
                    state_next = DONE;
                    res_err    = ERR_TIMEOUT;
                end else if (meter_busy) begin
                    state_next = WAIT_DONE;
                end
            end
            // Completion is checked first so a fall on the final cycle still captures.
            WAIT_DONE: begin
                if (!meter_busy) begin
                    state_next = CALC;
                end else if (timed_out) begin
                    state_next = DONE;
                    res_err    = ERR_TIMEOUT;
                end
            end
            CALC: begin
                if (div0) begin
                    state_next = DONE;
                    res_err    = ERR_DIV0;
                end else if (overflow) begin
                    state_next = DONE;
                    res_freq   = '1;
                    res_err    = ERR_OVERFLOW;
                end else begin
                    state_next = DIV;
                end
            end
            DIV: begin
                if (div_done) begin
                    state_next = DONE;
                    res_freq   = quotient;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        trig     = (state == TRIG);
        valid    = (state == DONE);
        busy     = (state != IDLE);
        div_load = (state == CALC) && !div0 && !overflow;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ca_r   <= '0;
            cb_r   <= '0;
            cnt    <= '0;
            freq_r <= '0;
            err_r  <= ERR_OK;
        end else begin
            if (capture) begin
                ca_r <= ca;
                cb_r <= cb;
            end
            if (state == TRIG)
                cnt <= '0;
            else if (state == WAIT_BUSY || state == WAIT_DONE)
                cnt <= cnt_next;
            if (state_next == DONE && state != DONE) begin
                freq_r <= res_freq;
                err_r  <= res_err;
            end
        end
    end

    assign freq = freq_r;
    assign err  = err_r;

    fm_divider u_divider (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load),
        .dividend (product),
        .divisor  (cb_r),
        .done     (div_done),
        .quotient (quotient)
    );

endmodule

// File: tb/tb_fm_host.sv
// Directed bench for fm_host: a behavioural meter drives each measurement and
// a per-cycle compare process checks valid/freq/err against an arithmetic model.
module tb_fm_host;

    localparam int unsigned REF = 50_000_000;
    localparam int          TMO = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        req = 1'b0;
    logic        meter_busy = 1'b0;
    logic [31:0] ca = '0;
    logic [31:0] cb = '0;
    logic        trig, valid, busy;
    logic [31:0] freq;
    logic [1:0]  err;

    int          cyc = 0;
    int          checks = 0;
    int          passes = 0;
    int          exp_vcycle = -1;
    logic [31:0] exp_freq = '0;
    logic [1:0]  exp_err = '0;
    logic [31:0] held_freq = '0;
    logic [1:0]  held_err = '0;
    int          last_valid = -1;
    int          trig_total = 0;

    fm_host #(.REF_HZ(REF), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .trig       (trig),
        .meter_busy (meter_busy),
        .ca         (ca),
        .cb         (cb),
        .freq       (freq),
        .valid      (valid),
        .err        (err),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act === expv)
            passes++;
        else
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    endtask

    // Result of a completed measurement, straight from the arithmetic definition.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] f, output logic [1:0] e);
        logic [63:0] p;
        p = 64'(a) * 64'(REF);
        if (b == '0) begin
            f = '0;
            e = 2'd2;
        end else if (p[63:32] >= b) begin
            f = '1;
            e = 2'd3;
        end else begin
            f = 32'(p / 64'(b));
            e = 2'd0;
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            held_freq = '0;
            held_err  = '0;
            check("reset_outputs", {valid, trig, busy, freq, err}, '0);
        end else begin
            if (cyc == exp_vcycle) begin
                held_freq = exp_freq;
                held_err  = exp_err;
            end
            check("outputs", {valid, freq, err}, {(cyc == exp_vcycle), held_freq, held_err});
            if (valid) last_valid = cyc;
            if (trig) trig_total++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One measurement: req pulse, meter raises busy d1 cycles after the wait
    // starts (w) and drops it at c = w + d1 + d2.
    task automatic run(input logic [31:0] a, input logic [31:0] b, input int d1, input int d2,
                       input bit no_rise, input bit no_fall, input bit mid_req,
                       output int w, output int c);
        int p, tr0, guard;
        logic [31:0] f;
        logic [1:0]  e;
        tr0 = trig_total;
        p   = cyc;
        req = 1'b1;
        step();
        req = 1'b0;
        guard = 0;
        while (!trig && guard < 8) begin
            step();
            guard++;
        end
        check("trig_seen", trig, 1);
        w = cyc + 1;
        c = w + d1 + d2;
        if (!trig) return;
        check("req_to_trig", cyc - p, 1);
        ca = a;
        cb = b;
        if (no_rise || no_fall || (c - w + 1) > TMO) begin
            exp_freq   = '0;
            exp_err    = 2'd1;
            exp_vcycle = w + TMO;
        end else begin
            model(a, b, f, e);
            exp_freq   = f;
            exp_err    = e;
            exp_vcycle = c + ((e == 2'd0) ? 34 : 2);
        end
        while (cyc < w + d1) step();
        if (!no_rise) meter_busy = 1'b1;
        if (mid_req) req = 1'b1;
        step();
        req = 1'b0;
        while (cyc < c) step();
        if (!no_fall) meter_busy = 1'b0;
        while (cyc < exp_vcycle + 3) step();
        meter_busy = 1'b0;
        check("one_trig", trig_total - tr0, 1);
        check("idle_after", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int w, c, tr0, guard;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        run(32'd1000, 32'd50_000_000, 2, 5, 0, 0, 0, w, c);
        check("s1_freq", freq, 1000);
        check("s1_err", err, 0);
        check("s1_latency", last_valid - c, 34);

        run(32'd3, 32'd7, 0, 3, 0, 0, 1, w, c);
        check("s2_freq", freq, 21_428_571);
        check("s2_err", err, 0);

        run(32'd5, 32'd0, 1, 1, 0, 0, 0, w, c);
        check("div0_freq", freq, 0);
        check("div0_err", err, 2);
        check("div0_latency", last_valid - c, 2);

        run(32'hFFFF_FFFF, 32'd1, 0, 2, 0, 0, 0, w, c);
        check("ovf_freq", freq, 32'hFFFF_FFFF);
        check("ovf_err", err, 3);

        run(32'd1_000_000, 32'd11641, 0, 2, 0, 0, 0, w, c);
        check("ovf_edge_err", err, 3);
        run(32'd1_000_000, 32'd11642, 0, 2, 0, 0, 0, w, c);
        check("ovf_edge_ok_err", err, 0);

        run(32'd7, 32'd7, 0, 2, 0, 1, 0, w, c);
        check("tmo_freq", freq, 0);
        check("tmo_err", err, 1);
        check("tmo_latency", last_valid - w, 100);

        run(32'd12345, 32'd1_000_000, 10, 89, 0, 0, 0, w, c);
        check("tie_freq", freq, 617_250);
        check("tie_err", err, 0);
        run(32'd12345, 32'd1_000_000, 10, 90, 0, 0, 0, w, c);
        check("late_err", err, 1);

        run(32'd1, 32'd1, 0, 5, 1, 0, 0, w, c);
        check("norise_err", err, 1);
        check("norise_latency", last_valid - w, 100);

        // Reset during DIV with req held high.
        tr0 = trig_total;
        exp_vcycle = -1;
        req = 1'b1;
        guard = 0;
        while (!trig && guard < 8) begin
            step();
            guard++;
        end
        check("rst_trig_seen", trig, 1);
        w  = cyc + 1;
        ca = 32'd40;
        cb = 32'd9;
        while (cyc < w + 1) step();
        meter_busy = 1'b1;
        while (cyc < w + 3) step();
        meter_busy = 1'b0;
        c = w + 3;
        while (cyc < c + 10) step();
        check("div_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_trig", trig, 0);
        check("abort_busy", busy, 0);
        check("abort_valid", valid, 0);
        check("held_req_one_trig", trig_total - tr0, 1);
        req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        run(32'd1000, 32'd1_000_000, 1, 1, 0, 0, 0, w, c);
        check("post_rst_freq", freq, 50_000);
        check("post_rst_err", err, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
